// File: rtl/mips_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : mips_boot_loader
// Purpose  : Receives a byte-stream program image (header N, N data words,
//            checksum word), writes the data words into instruction memory
//            and releases the core's reset once the checksum has matched.
// Revision : 1.0 - initial release
// ============================================================================
module mips_boot_loader #(
  parameter int WORD_WIDTH    = 32,
  parameter int DEPTH         = 1024,
  parameter int MEM_ADDR_SIZE = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     imem_we,
  output logic [MEM_ADDR_SIZE-1:0] imem_addr,
  output logic [WORD_WIDTH-1:0]    imem_wdata,
  output logic                     cpu_reset_n,
  output logic                     load_done,
  output logic                     load_error,
  output logic [$clog2(DEPTH):0]   words_loaded
);

  localparam int                    CNT_W      = $clog2(DEPTH) + 1;
  localparam int                    PART_W     = WORD_WIDTH - 8;
  localparam logic [WORD_WIDTH-1:0] DEPTH_WORD = WORD_WIDTH'(DEPTH);

  typedef enum logic [2:0] {
    ST_HEADER = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               byte_cnt_q, byte_cnt_d;
  // Only the first three bytes of a word need storing; the fourth byte
  // completes the word combinationally.
  logic [PART_W-1:0]        part_q, part_d;
  logic [CNT_W-1:0]         len_q, len_d;
  logic [CNT_W-1:0]         idx_q, idx_d;
  logic [WORD_WIDTH-1:0]    acc_q, acc_d;
  logic                     imem_we_q, imem_we_d;
  logic [MEM_ADDR_SIZE-1:0] imem_addr_q, imem_addr_d;
  logic [WORD_WIDTH-1:0]    imem_wdata_q, imem_wdata_d;
  logic                     load_done_q, load_done_d;
  logic                     load_error_q, load_error_d;
  logic                     cpu_reset_n_q, cpu_reset_n_d;

  logic                     accept;
  logic                     word_done;
  logic [WORD_WIDTH-1:0]    new_word;
  logic [CNT_W-1:0]         idx_next;

  assign rx_ready  = (state_q == ST_HEADER) || (state_q == ST_LOAD) ||
                     (state_q == ST_CHECK);
  assign accept    = rx_valid && rx_ready;
  assign word_done = accept && (byte_cnt_q == 2'd3);
  // Big-endian assembly: earlier bytes sit higher in the word.
  assign new_word  = {part_q, rx_data};
  assign idx_next  = idx_q + CNT_W'(1);

  // Next-state, word assembly, memory write and status computation.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    part_d        = part_q;
    len_d         = len_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    load_done_d   = load_done_q;
    load_error_d  = load_error_q;
    cpu_reset_n_d = cpu_reset_n_q;

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      part_d     = new_word[PART_W-1:0];
    end

    if (word_done) begin
      unique case (state_q)
        ST_HEADER: begin
          if (new_word > DEPTH_WORD) begin
            state_d      = ST_ERROR;
            load_error_d = 1'b1;
          end else if (new_word == '0) begin
            state_d = ST_CHECK;
          end else begin
            len_d   = new_word[CNT_W-1:0];
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          imem_we_d    = 1'b1;
          imem_wdata_d = new_word;
          imem_addr_d  = MEM_ADDR_SIZE'({idx_q, 2'b00});
          acc_d        = acc_q + new_word;
          idx_d        = idx_next;
          if (idx_next == len_q) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (new_word == acc_q) begin
            state_d       = ST_DONE;
            load_done_d   = 1'b1;
            cpu_reset_n_d = 1'b1;
          end else begin
            state_d      = ST_ERROR;
            load_error_d = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HEADER;
      byte_cnt_q    <= 2'd0;
      part_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      load_done_q   <= 1'b0;
      load_error_q  <= 1'b0;
      cpu_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      part_q        <= part_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      load_done_q   <= load_done_d;
      load_error_q  <= load_error_d;
      cpu_reset_n_q <= cpu_reset_n_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign cpu_reset_n  = cpu_reset_n_q;
  // The write index never exceeds N, so it doubles as the loaded-word count.
  assign words_loaded = idx_q;

endmodule
`default_nettype wire
